// File: rtl/dcache_ahb_burst_ctrl_if.sv
// rtl/dcache_ahb_burst_ctrl_if.sv - request/response and AHB-Lite signal bundle for the data cache
//
// Request side : req_valid/req_ready handshake, req_addr, req_wdata, req_write, req_size
// Response side: resp_valid pulse, resp_rdata, resp_err
// AHB side     : haddr, hwdata, htrans, hwrite, hsize, hburst, hprot out; hrdata, hready, hresp in
// modport master: the cache controller (it is the AHB master)
// modport slave : the environment (load/store unit plus AHB slave)

interface dcache_ahb_burst_ctrl_if #(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_LENGTH = 32
);
    logic                   req_valid;
    logic [ADDR_LENGTH-1:0] req_addr;
    logic [WORD_SIZE-1:0]   req_wdata;
    logic                   req_write;
    logic [2:0]             req_size;
    logic                   req_ready;

    logic                   resp_valid;
    logic [WORD_SIZE-1:0]   resp_rdata;
    logic                   resp_err;

    logic [ADDR_LENGTH-1:0] haddr;
    logic [WORD_SIZE-1:0]   hwdata;
    logic [1:0]             htrans;
    logic                   hwrite;
    logic [2:0]             hsize;
    logic [2:0]             hburst;
    logic [3:0]             hprot;
    logic [WORD_SIZE-1:0]   hrdata;
    logic                   hready;
    logic                   hresp;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, req_size,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output haddr, hwdata, htrans, hwrite, hsize, hburst, hprot,
        input  hrdata, hready, hresp
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, req_size,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  haddr, hwdata, htrans, hwrite, hsize, hburst, hprot,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/dcache_ahb_burst_ctrl.sv
// rtl/dcache_ahb_burst_ctrl.sv - direct-mapped write-through data cache with AHB-Lite burst refill
//
// clk : clock, all logic on the rising edge
// rst : synchronous active-high reset; restarts the tag flush from line 0
// bus : dcache_ahb_burst_ctrl_if.master
//       load/store requests in, one-cycle responses out (rdata, err),
//       AHB-Lite master port: incrementing burst line refills, single-beat write-through stores

module dcache_ahb_burst_ctrl #(
    parameter int WORD_SIZE   = 32,
    parameter int CACHE_SIZE  = 4096,
    parameter int ADDR_LENGTH = 32,
    parameter int LINE_WORDS  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    dcache_ahb_burst_ctrl_if.master        bus
);
    localparam int BYTES        = WORD_SIZE / 8;
    localparam int OFFSET_WIDTH = $clog2(BYTES);
    localparam int WOFF_WIDTH   = $clog2(LINE_WORDS);
    localparam int NUM_LINES    = CACHE_SIZE / (BYTES * LINE_WORDS);
    localparam int INDEX_WIDTH  = $clog2(NUM_LINES);
    localparam int TAG_WIDTH    = ADDR_LENGTH - INDEX_WIDTH - WOFF_WIDTH - OFFSET_WIDTH;
    localparam int CNT_WIDTH    = WOFF_WIDTH + 1;
    localparam int NUM_WORDS    = NUM_LINES * LINE_WORDS;

    localparam logic [2:0] HBURST = (LINE_WORDS == 4)  ? 3'b011 :
                                    (LINE_WORDS == 8)  ? 3'b101 :
                                    (LINE_WORDS == 16) ? 3'b111 : 3'b001;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'(OFFSET_WIDTH);

    typedef enum logic [2:0] {
        S_FLUSH   = 3'd0,
        S_IDLE    = 3'd1,
        S_CMP_TAG = 3'd2,
        S_REFILL  = 3'd3,
        S_WR_ADDR = 3'd4,
        S_WR_DATA = 3'd5
    } state_t;

    state_t state, state_n;

    // Registered request
    logic [ADDR_LENGTH-1:0] req_addr_r;
    logic [WORD_SIZE-1:0]   req_wdata_r;
    logic                   req_write_r;
    logic [2:0]             req_size_r;

    logic [INDEX_WIDTH-1:0] flush_cnt;
    logic [CNT_WIDTH-1:0]   a_cnt;
    logic [CNT_WIDTH-1:0]   d_cnt;
    logic                   err_r;

    // Tag RAM entries are {valid, tag}
    logic [TAG_WIDTH:0]     tag_mem  [NUM_LINES];
    logic [WORD_SIZE-1:0]   data_mem [NUM_WORDS];

    logic [TAG_WIDTH-1:0]    r_tag;
    logic [INDEX_WIDTH-1:0]  r_index;
    logic [WOFF_WIDTH-1:0]   r_woff;
    logic [OFFSET_WIDTH-1:0] r_boff;
    logic [TAG_WIDTH:0]      tag_entry;
    logic                    hit;
    logic [WORD_SIZE-1:0]    hit_word;
    logic [BYTES-1:0]        wr_mask;
    logic [WORD_SIZE-1:0]    merged_word;
    logic [ADDR_LENGTH-1:0]  beat_addr;
    logic                    addr_active;
    logic                    data_pending;

    logic                                tag_we;
    logic [INDEX_WIDTH-1:0]              tag_wa;
    logic [TAG_WIDTH:0]                  tag_wd;
    logic                                data_we;
    logic [INDEX_WIDTH+WOFF_WIDTH-1:0]   data_wa;
    logic [WORD_SIZE-1:0]                data_wd;
    logic                                a_inc;
    logic                                d_inc;
    logic                                err_set;
    logic                                cnt_clr;
    logic                                accept;

    // Byte lanes touched by a store of 2**size bytes at byte offset boff.
    function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size,
                                                   input logic [OFFSET_WIDTH-1:0] boff);
        logic [BYTES-1:0] m;
        int nbytes;
        m = '0;
        nbytes = (int'(size) >= OFFSET_WIDTH) ? BYTES : (1 << size);
        for (int i = 0; i < BYTES; i++) begin
            if (i >= int'(boff) && i < int'(boff) + nbytes) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign r_tag     = req_addr_r[ADDR_LENGTH-1 -: TAG_WIDTH];
    assign r_index   = req_addr_r[OFFSET_WIDTH+WOFF_WIDTH +: INDEX_WIDTH];
    assign r_woff    = req_addr_r[OFFSET_WIDTH +: WOFF_WIDTH];
    assign r_boff    = req_addr_r[OFFSET_WIDTH-1:0];
    assign tag_entry = tag_mem[r_index];
    assign hit       = tag_entry[TAG_WIDTH] && (tag_entry[TAG_WIDTH-1:0] == r_tag);
    assign hit_word  = data_mem[{r_index, r_woff}];
    assign wr_mask   = lane_mask(req_size_r, r_boff);

    // Line-aligned base with the beat number dropped into the word-offset field.
    assign beat_addr = {req_addr_r[ADDR_LENGTH-1:OFFSET_WIDTH+WOFF_WIDTH],
                        a_cnt[WOFF_WIDTH-1:0], {OFFSET_WIDTH{1'b0}}};

    // An error in any data phase stops further address phases from the next cycle.
    assign addr_active  = (a_cnt < CNT_WIDTH'(LINE_WORDS)) && !err_r;
    // Addresses accepted but data not yet returned.
    assign data_pending = (d_cnt != a_cnt);

    assign accept    = bus.req_ready && bus.req_valid;
    assign bus.hprot = 4'b0011;

    always_comb begin
        merged_word = hit_word;
        for (int i = 0; i < BYTES; i++) begin
            if (wr_mask[i]) begin
                merged_word[8*i +: 8] = req_wdata_r[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_n        = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        bus.htrans     = HTRANS_IDLE;
        bus.haddr      = '0;
        bus.hwrite     = 1'b0;
        bus.hwdata     = '0;
        bus.hsize      = HSIZE_WORD;
        bus.hburst     = 3'b000;
        tag_we         = 1'b0;
        tag_wa         = flush_cnt;
        tag_wd         = '0;
        data_we        = 1'b0;
        data_wa        = {r_index, r_woff};
        data_wd        = merged_word;
        a_inc          = 1'b0;
        d_inc          = 1'b0;
        err_set        = 1'b0;
        cnt_clr        = 1'b0;

        case (state)
            S_FLUSH: begin
                tag_we = 1'b1;
                if (flush_cnt == INDEX_WIDTH'(NUM_LINES - 1)) begin
                    state_n = S_IDLE;
                end
            end

            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_n = S_CMP_TAG;
                end
            end

            S_CMP_TAG: begin
                if (!req_write_r) begin
                    if (hit) begin
                        // Hit pipeline: respond and accept the next request in the same cycle.
                        bus.resp_valid = 1'b1;
                        bus.resp_rdata = hit_word;
                        bus.req_ready  = 1'b1;
                        state_n        = bus.req_valid ? S_CMP_TAG : S_IDLE;
                    end else begin
                        cnt_clr = 1'b1;
                        state_n = S_REFILL;
                    end
                end else begin
                    // Write-through: merge into a cached copy, never allocate on miss.
                    data_we = hit;
                    state_n = S_WR_ADDR;
                end
            end

            S_REFILL: begin
                bus.hburst = HBURST;
                if (addr_active) begin
                    bus.htrans = (a_cnt == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                    bus.haddr  = beat_addr;
                    a_inc      = bus.hready;
                end
                if (data_pending) begin
                    if (bus.hresp) begin
                        // Two-cycle error response: first cycle only blocks new beats.
                        err_set = 1'b1;
                        if (bus.hready) begin
                            bus.resp_valid = 1'b1;
                            bus.resp_err   = 1'b1;
                            state_n        = S_IDLE;
                        end
                    end else if (bus.hready) begin
                        data_we = 1'b1;
                        data_wa = {r_index, d_cnt[WOFF_WIDTH-1:0]};
                        data_wd = bus.hrdata;
                        d_inc   = 1'b1;
                        if (d_cnt == CNT_WIDTH'(LINE_WORDS - 1)) begin
                            // Line complete: validate it and let CMP_TAG re-look-up and respond.
                            tag_we  = 1'b1;
                            tag_wa  = r_index;
                            tag_wd  = {1'b1, r_tag};
                            state_n = S_CMP_TAG;
                        end
                    end
                end
            end

            S_WR_ADDR: begin
                bus.htrans = HTRANS_NONSEQ;
                bus.haddr  = req_addr_r;
                bus.hwrite = 1'b1;
                bus.hsize  = req_size_r;
                if (bus.hready) begin
                    state_n = S_WR_DATA;
                end
            end

            S_WR_DATA: begin
                bus.hwdata = req_wdata_r;
                if (bus.hready) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_err   = bus.hresp;
                    state_n        = S_IDLE;
                end
            end

            default: begin
                state_n = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FLUSH;
            flush_cnt   <= '0;
            a_cnt       <= '0;
            d_cnt       <= '0;
            err_r       <= 1'b0;
            req_addr_r  <= '0;
            req_wdata_r <= '0;
            req_write_r <= 1'b0;
            req_size_r  <= 3'b000;
        end else begin
            state <= state_n;
            if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + INDEX_WIDTH'(1);
            end
            if (accept) begin
                req_addr_r  <= bus.req_addr;
                req_wdata_r <= bus.req_wdata;
                req_write_r <= bus.req_write;
                req_size_r  <= bus.req_size;
            end
            if (cnt_clr) begin
                a_cnt <= '0;
                d_cnt <= '0;
                err_r <= 1'b0;
            end else begin
                if (a_inc) begin
                    a_cnt <= a_cnt + CNT_WIDTH'(1);
                end
                if (d_inc) begin
                    d_cnt <= d_cnt + CNT_WIDTH'(1);
                end
                if (err_set) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    // RAM write ports; a reset cycle must not commit a half-finished refill.
    always_ff @(posedge clk) begin
        if (!rst && tag_we) begin
            tag_mem[tag_wa] <= tag_wd;
        end
        if (!rst && data_we) begin
            data_mem[data_wa] <= data_wd;
        end
    end
endmodule

// File: doc/dcache_ahb_burst_ctrl.md
# dcache_ahb_burst_ctrl

Direct-mapped, write-through, no-write-allocate data cache with multi-word lines, refilled over AHB-Lite with fixed-length incrementing bursts. It sits between the core load/store unit and the AHB master port. It generalises the single-word cache controller with three additions:

- parametrised line length;
- byte/halfword write merging with write-through on every store;
- error reporting back to the requester.

## Interface
Parameters:
- WORD_SIZE, 32, data word width in bits (multiple of 8)
- CACHE_SIZE, 4096, data capacity in bytes
- ADDR_LENGTH, 32, address width
- LINE_WORDS, 4, words per line; power of two, 2..16
- Derived: OFFSET_WIDTH=log2(WORD_SIZE/8), WOFF_WIDTH=log2(LINE_WORDS), NUM_LINES=CACHE_SIZE/(WORD_SIZE/8*LINE_WORDS), INDEX_WIDTH=log2(NUM_LINES), TAG_WIDTH=ADDR_LENGTH-INDEX_WIDTH-WOFF_WIDTH-OFFSET_WIDTH

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_addr  in  ADDR_LENGTH  byte address
- req_wdata  in  WORD_SIZE  store data, lane-aligned
- req_write  in  1  1=store, 0=load
- req_size  in  3  0=byte, 1=half, 2=word
- req_ready  out  1  request accepted when req_valid&&req_ready
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  WORD_SIZE  full load word; 0 for stores and errors
- resp_err  out  1  AHB error on this request; qualified by resp_valid
- haddr  out  ADDR_LENGTH  AHB address
- hwdata  out  WORD_SIZE  AHB write data
- htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ
- hwrite  out  1  AHB write
- hsize  out  3  AHB size
- hburst  out  3  AHB burst type
- hprot  out  4  constant 4'b0011
- hrdata  in  WORD_SIZE  AHB read data
- hready  in  1  transfer done / address accepted
- hresp  in  1  1=ERROR

## Operation
- Request fields are registered on acceptance.
- Address split: tag, index, word offset, byte offset. Tag RAM entries are {valid, tag}.
- FLUSH (entered from reset): clears the valid bit of one line per cycle; req_ready=0. After NUM_LINES cycles → IDLE.
- IDLE: req_ready=1; on acceptance → CMP_TAG.
- CMP_TAG, load hit:
  - resp_valid=1; resp_rdata=addressed word.
  - req_ready=1; next state is CMP_TAG if a new request is accepted, else IDLE.
- CMP_TAG, load miss → REFILL.
- CMP_TAG, store (hit or miss): req_ready=0 → WR_ADDR.
  - On a hit, the cached word is byte-merged at the end of the cycle. Lanes come from req_size and the byte offset; misaligned requests are the requester's fault.
- REFILL:
  - Burst address base is the line-aligned address. hsize=word.
  - hburst: INCR4 (011) for LINE_WORDS=4, INCR8 (101) for 8, INCR16 (111) for 16, INCR (001) for 2.
  - Address counter a_cnt: beat 0 NONSEQ, later beats SEQ. haddr=base+a_cnt*bytes; advances only when hready=1. After the last address, htrans=IDLE.
  - Data counter d_cnt: each hready=1 data-phase cycle writes hrdata into data[index][d_cnt].
  - The last beat writes {1,tag} to the tag RAM → CMP_TAG, which re-looks up, hits and responds.
- WR_ADDR: NONSEQ, haddr=req_addr_r, hwrite=1, hsize=req_size_r, hburst=000. Held until hready=1 → WR_DATA.
- WR_DATA: hwdata=req_wdata_r. When hready=1: resp_valid=1, resp_err=hresp → IDLE. No allocation on a store miss.
- Error during REFILL (hresp=1 in a data phase):
  - htrans=IDLE from the next cycle; no further beats are issued.
  - The tag stays invalid; already-written data words are harmless.
  - When hready=1 with hresp=1: resp_valid=1, resp_err=1, resp_rdata=0 → IDLE.
- Outputs not driven by the current state take their defaults: htrans=00, haddr=0, hwrite=0, hwdata=0, hsize=010, hburst=000.

## Timing
- Values while rst=1 and in the first cycle after: state=FLUSH, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, htrans=00, haddr=0, hwrite=0, hwdata=0, hsize=010, hburst=000, hprot=0011.
- Asserting rst mid-burst:
  - htrans=IDLE from the next edge.
  - The in-flight request is dropped with no response.
  - FLUSH restarts from line 0.
- Load hit: resp_valid one cycle after acceptance; back-to-back hits give one result per cycle.
- Load miss, zero-wait slave, acceptance in cycle 0:
  - miss detected in cycle 1;
  - addresses in cycles 2..LINE_WORDS+1;
  - last data in cycle LINE_WORDS+2;
  - resp_valid in cycle LINE_WORDS+3 (cycle 7 for LINE_WORDS=4).
- Store, zero-wait slave: WR_ADDR in cycle 2, resp_valid in cycle 3, ready again in cycle 4 (IDLE).
- Wait states (hready=0) stretch the current phase. The address, control and hwdata outputs stay stable while hready=0.
- Wrap-around: a_cnt and d_cnt are WOFF_WIDTH+1 bits and never wrap within a burst. The flush counter terminates at NUM_LINES-1.

## Test plan
- Reset then idle: req_ready=0 for exactly NUM_LINES cycles (256 at defaults), then 1; htrans=00 throughout.
- Load 0x100 after flush, zero-wait slave:
  - AHB sees INCR4 with addresses 0x100/0x104/0x108/0x10C, NONSEQ then three SEQ;
  - resp_valid in cycle 7 with the word slave returned for 0x100.
  - A following load of 0x108 hits in 1 cycle with no AHB traffic.
- Store byte 0xAB to 0x105 (line cached, old word 0x11223344): one NONSEQ write with hsize=0 and hwdata=req_wdata. A reload of 0x104 then returns 0x1122AB44 without AHB traffic.
- Store to an uncached 0x2000: single write, resp_valid with resp_err=0. A load of 0x2000 then misses and triggers a refill.
- Refill with hresp=1 on beat 2:
  - no further SEQ beats;
  - resp_valid with resp_err=1 and resp_rdata=0;
  - a retry of the same address re-refills from scratch.
- Two wait states per beat during a refill: haddr and htrans stay stable while hready=0, and the response arrives 8 cycles later than in the zero-wait case. Asserting rst in beat 1 drives htrans=00 at the next edge and restarts FLUSH.
